mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of both requesters and the memory port.
REQ-002 Parameter AW, default 32, address width of both requesters and the memory port.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Ports req0, we0, adr0, wd0: input, 1/1/AW/DW, port 0 (CPU) request, write enable, address, write data.
REQ-006 Ports req1, we1, adr1, wd1: input, 1/1/AW/DW, port 1 (loader) request, write enable, address, write data.
REQ-007 Ports gnt0, gnt1: output, 1 each, access-cycle indicator per port.
REQ-008 Ports ack0, ack1: output, 1 each, completion pulse per port.
REQ-009 Ports rd0, rd1: output, DW each, read data per port.
REQ-010 Ports mem_en, mem_we, mem_adr, mem_wd: output, 1/1/AW/DW, shared memory strobe, write enable, address, write data.
REQ-011 Port mem_rd: input, DW, memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-012 FSM states SHALL be IDLE, ACC0, ACC1, RESP0, RESP1.
REQ-013 Arbitration SHALL occur in IDLE, RESP0 and RESP1 on sampled req0/req1, with no other state arbitrating.
REQ-014 Only one request pending SHALL win; both pending SHALL go to the port not served last (round-robin pointer last).
REQ-015 The winner's we/adr/wd SHALL be registered into mem_we/mem_adr/mem_wd on the arbitration edge; next state ACCx.
REQ-016 In ACCx: mem_en=1, gntx=1, other gnt=0, memory outputs hold captured values; next state RESPx unconditionally.
REQ-017 In RESPx: ackx=1 for one cycle; for reads rdx SHALL equal mem_rd in that cycle and hold until the next ackx; writes leave rdx unchanged.
REQ-018 last SHALL update to x on the ACCx->RESPx edge.
REQ-019 Access latency: req seen at edge N -> gnt in cycle N+1 -> ack in cycle N+2; peak throughput one access per 2 cycles, back-to-back via RESP->ACC.
REQ-020 A requester SHALL hold req and its inputs stable until gnt; req deasserted before being sampled is never served.
REQ-021 req still high in RESPx (x's own cycle) SHALL be treated as a new request.
REQ-022 In IDLE/RESP with no request: next state IDLE, mem_en=0, mem_* hold last values.
REQ-023 mem_en, gnt0, gnt1, ack0, ack1 SHALL never assert outside the states above; at most one gnt and one ack per cycle.
REQ-024 Illegal state encodings SHALL return to IDLE next cycle with all strobes 0.

Reset
REQ-025 reset low SHALL asynchronously force state=IDLE, last=1 (port 0 favoured first), and all outputs to 0 (mem_adr, mem_wd, rd0, rd1 included).
REQ-026 reset asserted mid-access (ACCx or RESPx) SHALL abort it: no ack issued, no pending access retained after release.
REQ-027 First arbitration SHALL occur on the first rising edge with reset high.

Verification
REQ-028 Single read: req0=1, we0=0, adr0=0x20, mem_rd=0xCAFE0001 -> gnt0 cycle N+1 with mem_adr=0x20, mem_en=1; ack0 and rd0=0xCAFE0001 cycle N+2.
REQ-029 Write: req1=1, we1=1, adr1=0x40, wd1=0x12345678 -> cycle N+1 mem_en=1, mem_we=1, mem_adr=0x40, mem_wd=0x12345678, gnt1=1; ack1 N+2; rd1 unchanged.
REQ-030 Contention after reset: req0=req1=1 held -> grant order 0,1,0,1 at cycles 1,3,5,7; gnt never both high.
REQ-031 Back-to-back: req0 held high for 3 accesses -> gnt0 in cycles 1,3,5, ack0 in cycles 2,4,6, no IDLE cycle between.
REQ-032 Reset mid-access: reset low during ACC0 -> all outputs 0 immediately; ack0 never pulses; after release with no req, mem_en stays 0.
REQ-033 Short request: req1 pulsed high for half a cycle between edges -> no gnt1, no mem_en.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for two requesters sharing one memory port.
// Each access is an ACC strobe cycle followed by a RESP acknowledge cycle.
module mem_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] adr0,
  input  logic [DW-1:0] wd0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC0  = 3'd1,
    ACC1  = 3'd2,
    RESP0 = 3'd3,
    RESP1 = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_adr;
  logic [DW-1:0] r_mem_wd;
  logic [DW-1:0] r_rd0;
  logic [DW-1:0] r_rd1;

  logic w_arb;
  logic w_win0;
  logic w_win1;
  logic w_rsp0_rd;
  logic w_rsp1_rd;

  assign w_arb = (r_state == IDLE) ||
                 (r_state == RESP0) ||
                 (r_state == RESP1);

  // r_last names the port served most recently; the other wins a tie
  assign w_win0 = w_arb && req0 && (!req1 || r_last);
  assign w_win1 = w_arb && req1 && (!req0 || !r_last);

  assign w_rsp0_rd = (r_state == RESP0) && !r_mem_we;
  assign w_rsp1_rd = (r_state == RESP1) && !r_mem_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_adr <= '0;
      r_mem_wd  <= '0;
      r_rd0     <= '0;
      r_rd1     <= '0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_mem_en <= 1'b0;
      unique case (r_state)
        IDLE, RESP0, RESP1: begin
          if (w_rsp0_rd) r_rd0 <= mem_rd;
          if (w_rsp1_rd) r_rd1 <= mem_rd;
          r_state <= IDLE;
          if (w_win0) begin
            r_state   <= ACC0;
            r_gnt0    <= 1'b1;
            r_mem_en  <= 1'b1;
            r_mem_we  <= we0;
            r_mem_adr <= adr0;
            r_mem_wd  <= wd0;
          end else if (w_win1) begin
            r_state   <= ACC1;
            r_gnt1    <= 1'b1;
            r_mem_en  <= 1'b1;
            r_mem_we  <= we1;
            r_mem_adr <= adr1;
            r_mem_wd  <= wd1;
          end
        end
        ACC0: begin
          r_state <= RESP0;
          r_ack0  <= 1'b1;
          r_last  <= 1'b0;
        end
        ACC1: begin
          r_state <= RESP1;
          r_ack1  <= 1'b1;
          r_last  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign mem_en  = r_mem_en;
  assign mem_we  = r_mem_we;
  assign mem_adr = r_mem_adr;
  assign mem_wd  = r_mem_wd;

  // read data is forwarded in the ack cycle, then held
  assign rd0 = w_rsp0_rd ? mem_rd : r_rd0;
  assign rd1 = w_rsp1_rd ? mem_rd : r_rd1;

endmodule
